spi_slave_responder: RTL
========================

# spi_slave_responder

Synthesizable SPI slave (responder) for the single-channel link driven by the `SPI` master block. It shifts in one `SPI_WIDTH`-bit word from MOSI per SS frame and returns one word on MISO, both MSB first. Local logic hands it a reply word and collects the received word through simple valid/ready ports. It replaces behavioural slave models on-chip and in FPGA loopback setups, and runs entirely in the `clock` domain by oversampling SCLK, SS and MOSI.

## Interface
- `SPI_WIDTH`, 12: bits per frame; legal range 2–32.
- `SYNC_STAGES`, 2: synchronizer flops on SCLK, SS and MOSI; must be ≥2.
- `clock`  in  1  system clock; must run ≥ 12× SCLK.
- `reset`  in  1  synchronous, active-high reset.
- `SCLK`  in  1  SPI clock from the master; idles low.
- `SS`  in  1  slave select from the master; active low.
- `MOSI`  in  1  master-to-slave data.
- `MISO`  out  1  slave-to-master data; registered.
- `tx_data`  in  SPI_WIDTH  reply word for the next frame.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  reply holding register is empty.
- `rx_data`  out  SPI_WIDTH  last complete received word; held until the next completion.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` updates.
- `underrun`  out  1  one-cycle pulse when a frame starts with no reply loaded.
- `aborted`  out  1  one-cycle pulse when SS rises mid-frame.
- `overrun`  out  1  one-cycle pulse on each falling SCLK edge after the word is complete.

## Operation
- Inputs are synchronized, then edge-detected against the previous synchronized sample. This produces one-cycle `sclk_rise`, `sclk_fall`, `ss_fall` and `ss_rise` strobes.
- Reply holding register:
  - Loaded when `tx_valid && tx_ready`.
  - `tx_ready` goes low after the load and returns high when the frame start consumes the word.
- FSM states are `ARMING`, `IDLE`, `ACTIVE` and `COMPLETE`.
- `ARMING`:
  - Entered on reset.
  - Moves to `IDLE` once synchronized SS is high.
  - The block never joins a frame that is already in progress.
- `IDLE`, on `ss_fall`:
  - Load `tx_shift` from the holding register. If the holding register is empty, load 0 and pulse `underrun`.
  - Clear `bit_cnt` and `rx_shift`.
  - Drive `MISO` ← MSB of the loaded word.
  - Go to `ACTIVE`.
- `ACTIVE`:
  - On `sclk_fall`: shift `rx_shift` left with synchronized MOSI into bit 0, shift `tx_shift` left with 0 in, and increment `bit_cnt`.
  - On `sclk_rise`: `MISO` ← `tx_shift[SPI_WIDTH-1]`.
  - On the fall that makes `bit_cnt == SPI_WIDTH`: `rx_data` ← the completed word, pulse `rx_valid`, go to `COMPLETE`.
  - On `ss_rise` with `bit_cnt < SPI_WIDTH`: pulse `aborted`, leave `rx_data` unchanged, go to `IDLE`.
- `COMPLETE`:
  - `MISO` is held at 0.
  - Each further `sclk_fall` pulses `overrun` and changes no other state.
  - On `ss_rise`, go to `IDLE`.
- Simultaneous events:
  - `ss_rise` together with the final `sclk_fall` counts as completion: pulse `rx_valid` and go to `IDLE`.
  - `ss_rise` wins over any other same-cycle `sclk` strobe.
- `bit_cnt` width is $clog2(SPI_WIDTH+1); it saturates and does not wrap.

## Timing
- Reset values: `MISO`=0, `tx_ready`=1, `rx_data`=0, and `rx_valid`, `underrun`, `aborted`, `overrun` all 0. Holding register, shift registers and counter are cleared. State is `ARMING`.
- Reset asserted mid-frame abandons the frame silently: no `aborted` pulse, MISO goes to 0.
- Pin-to-output latency is SYNC_STAGES+2 clocks (sync, edge register, output register). With the default this is 4 clocks for:
  - SS fall → MSB on `MISO`;
  - SCLK rise → next `MISO` bit;
  - final SCLK fall → `rx_valid`.
- Master constraint: sample MISO on the falling edge; the SCLK high phase must be ≥ 6 clocks.
- A reply accepted in the same cycle as `ss_fall` is not used for that frame. It is kept for the next frame.

## Structure
- Package `spi_slave_pkg` holds the state enum `spi_slave_state_t` and the constant `SPI_SLAVE_MIN_OVERSAMPLE = 12`.
- Sub-module `spi_slave_input_sync` has parameter `SYNC_STAGES` and contains the synchronizer plus edge detector for SCLK, SS and MOSI. Its outputs are the level signals and the four strobes.

## Test plan
- Basic frame: load `tx_data`=0x3F1, then a 12-bit frame with MOSI=0xA5C → `rx_data`=0xA5C with one `rx_valid` pulse; the master receives 0x3F1; `tx_ready` returns to 1.
- Underrun: frame with no reply loaded, MOSI=0x123 → `underrun` pulses once, the master receives 0x000, `rx_data`=0x123.
- Abort: SS rises after 7 bits → `aborted` pulses, no `rx_valid`, `rx_data` keeps its previous value; the next full frame with MOSI=0x0F0 → 0x0F0.
- Overrun: 14 SCLK cycles in one frame with MOSI first word 0xFFF → `rx_valid` on the 12th fall, `overrun` pulses twice, `MISO`=0 after the word.
- Back-to-back frames: 16 random frames, each with a reply reloaded in the SS-high gap → every rx/tx word matches; no `underrun`.
- Reset: reset mid-frame with SS held low → no outputs fire; the block stays in `ARMING` until SS rises; the following frame transfers correctly.

Source files
------------

// File: rtl/spi_slave_responder_pkg.sv
// spi_slave_pkg
// Shared types and constants for the SPI slave responder.
//   spi_slave_state_t        : responder FSM state encoding
//   SPI_SLAVE_MIN_OVERSAMPLE : minimum clock/SCLK frequency ratio the
//                              oversampling front end is designed for
package spi_slave_pkg;

    typedef enum logic [1:0] {
        ARMING   = 2'd0,
        IDLE     = 2'd1,
        ACTIVE   = 2'd2,
        COMPLETE = 2'd3
    } spi_slave_state_t;

    localparam int SPI_SLAVE_MIN_OVERSAMPLE = 12;

endpackage

// File: rtl/spi_slave_responder_if.sv
// spi_slave_responder_if
// The four SPI pins between a master and the responder.
//   SCLK : serial clock from the master, idles low
//   SS   : slave select from the master, active low
//   MOSI : master-to-slave data
//   MISO : slave-to-master data
// Modports: master drives SCLK/SS/MOSI, slave drives MISO.
interface spi_slave_responder_if;
    logic SCLK;
    logic SS;
    logic MOSI;
    logic MISO;

    modport master (output SCLK, output SS, output MOSI, input MISO);
    modport slave  (input SCLK, input SS, input MOSI, output MISO);
endinterface

// File: rtl/spi_slave_input_sync.sv
// spi_slave_input_sync
// Synchronizes SCLK, SS and MOSI into the clock domain and produces
// registered one-cycle edge strobes. Levels and strobes leave on the same
// register stage, so a strobe and the matching level are always aligned.
//   clock, reset            : system clock, synchronous active-high reset
//   sclk_in, ss_in, mosi_in : raw pins
//   ss_lvl, mosi_lvl        : synchronized levels
//   sclk_rise, sclk_fall    : SCLK edge strobes
//   ss_rise, ss_fall        : SS edge strobes
module spi_slave_input_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic sclk_in,
    input  logic ss_in,
    input  logic mosi_in,
    output logic ss_lvl,
    output logic mosi_lvl,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic ss_rise,
    output logic ss_fall
);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_lvl;

    // SS resets to the "selected" level so that a frame already running when
    // reset releases produces no ss_fall; the FSM then waits for a real high.
    always_ff @(posedge clock) begin
        if (reset) begin
            sclk_sync <= '0;
            ss_sync   <= '0;
            mosi_sync <= '0;
            sclk_lvl  <= 1'b0;
            ss_lvl    <= 1'b0;
            mosi_lvl  <= 1'b0;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            ss_rise   <= 1'b0;
            ss_fall   <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_in};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_in};
            sclk_lvl  <= sclk_sync[SYNC_STAGES-1];
            ss_lvl    <= ss_sync[SYNC_STAGES-1];
            mosi_lvl  <= mosi_sync[SYNC_STAGES-1];
            sclk_rise <= sclk_sync[SYNC_STAGES-1] & ~sclk_lvl;
            sclk_fall <= ~sclk_sync[SYNC_STAGES-1] & sclk_lvl;
            ss_rise   <= ss_sync[SYNC_STAGES-1] & ~ss_lvl;
            ss_fall   <= ~ss_sync[SYNC_STAGES-1] & ss_lvl;
        end
    end

endmodule

// File: rtl/spi_slave_responder.sv
// spi_slave_responder
// SPI slave that shifts in one SPI_WIDTH-bit word per SS frame (MSB first)
// and returns a reply word on MISO, fully oversampled in the clock domain.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ARMING   | after reset; wait for SS high so a running frame is skipped
//   IDLE     | SS high, waiting for ss_fall to start a frame
//   ACTIVE   | frame in progress, shifting on SCLK edges
//   COMPLETE | word received, extra SCLK falls flag overrun until SS rises
//
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   spi          : SPI pins (slave modport), MISO registered
//   tx_data/tx_valid/tx_ready : reply word handshake into holding register
//   rx_data/rx_valid          : received word, rx_valid pulses on update
//   underrun, aborted, overrun: one-cycle status pulses
module spi_slave_responder
    import spi_slave_pkg::*;
#(
    parameter int SPI_WIDTH   = 12,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    spi_slave_responder_if.slave spi,
    input  logic [SPI_WIDTH-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [SPI_WIDTH-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 underrun,
    output logic                 aborted,
    output logic                 overrun
);

    localparam int             CW       = $clog2(SPI_WIDTH + 1);
    localparam logic [CW-1:0]  CNT_FULL = CW'(SPI_WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(SPI_WIDTH - 1);

    logic ss_lvl, mosi_lvl;
    logic sclk_rise, sclk_fall, ss_rise, ss_fall;

    spi_slave_input_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clock     (clock),
        .reset     (reset),
        .sclk_in   (spi.SCLK),
        .ss_in     (spi.SS),
        .mosi_in   (spi.MOSI),
        .ss_lvl    (ss_lvl),
        .mosi_lvl  (mosi_lvl),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .ss_rise   (ss_rise),
        .ss_fall   (ss_fall)
    );

    spi_slave_state_t     state, state_next;
    logic [SPI_WIDTH-1:0] hold_word;
    logic                 hold_full;
    logic [SPI_WIDTH-1:0] tx_shift;
    logic [SPI_WIDTH-2:0] rx_shift;
    logic [SPI_WIDTH-1:0] rx_next;
    logic [CW-1:0]        bit_cnt;
    logic                 miso_q;

    logic start_frame, shift_bit, drive_bit, finish_word;
    logic abort_frame, flag_overrun, clear_miso;

    assign rx_next  = {rx_shift, mosi_lvl};
    assign tx_ready = ~hold_full;
    assign spi.MISO = miso_q;

    always_ff @(posedge clock) begin
        if (reset) state <= ARMING;
        else       state <= state_next;
    end

    always_comb begin
        state_next   = state;
        start_frame  = 1'b0;
        shift_bit    = 1'b0;
        drive_bit    = 1'b0;
        finish_word  = 1'b0;
        abort_frame  = 1'b0;
        flag_overrun = 1'b0;
        clear_miso   = 1'b0;
        case (state)
            ARMING: begin
                if (ss_lvl) state_next = IDLE;
            end
            IDLE: begin
                if (ss_fall) begin
                    start_frame = 1'b1;
                    state_next  = ACTIVE;
                end
            end
            ACTIVE: begin
                // ss_rise dominates, except that it still completes a word
                // whose final bit lands in the same cycle.
                if (ss_rise) begin
                    if (sclk_fall && bit_cnt == CNT_LAST) begin
                        shift_bit   = 1'b1;
                        finish_word = 1'b1;
                    end else begin
                        abort_frame = 1'b1;
                    end
                    clear_miso = 1'b1;
                    state_next = IDLE;
                end else if (sclk_fall) begin
                    shift_bit = 1'b1;
                    if (bit_cnt == CNT_LAST) begin
                        finish_word = 1'b1;
                        clear_miso  = 1'b1;
                        state_next  = COMPLETE;
                    end
                end else if (sclk_rise) begin
                    drive_bit = 1'b1;
                end
            end
            COMPLETE: begin
                if (ss_rise)        state_next   = IDLE;
                else if (sclk_fall) flag_overrun = 1'b1;
            end
            default: state_next = ARMING;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            hold_word <= '0;
            hold_full <= 1'b0;
            tx_shift  <= '0;
            rx_shift  <= '0;
            bit_cnt   <= '0;
            miso_q    <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            underrun  <= 1'b0;
            aborted   <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            rx_valid <= finish_word;
            aborted  <= abort_frame;
            overrun  <= flag_overrun;
            underrun <= start_frame & ~hold_full;

            // A word accepted in the ss_fall cycle finds hold_full low here,
            // so the frame underruns and the new word waits for the next one.
            if (start_frame && hold_full) begin
                hold_full <= 1'b0;
            end else if (tx_valid && !hold_full) begin
                hold_word <= tx_data;
                hold_full <= 1'b1;
            end

            if (start_frame) begin
                tx_shift <= hold_full ? hold_word : '0;
                rx_shift <= '0;
                bit_cnt  <= '0;
            end else if (shift_bit) begin
                tx_shift <= {tx_shift[SPI_WIDTH-2:0], 1'b0};
                rx_shift <= rx_next[SPI_WIDTH-2:0];
                if (bit_cnt != CNT_FULL) bit_cnt <= bit_cnt + 1'b1;
            end

            if (finish_word) rx_data <= rx_next;

            if (start_frame)     miso_q <= hold_full & hold_word[SPI_WIDTH-1];
            else if (clear_miso) miso_q <= 1'b0;
            else if (drive_bit)  miso_q <= tx_shift[SPI_WIDTH-1];
        end
    end

endmodule
